// File: rtl/seg_text_scroller.sv
// Eight-character ASCII window over a 32-entry message buffer for a serial text display.
// Short messages are shown statically; longer ones scroll by one character every STEP_DIV clocks.
module seg_text_scroller #(
  parameter int unsigned MAX_LEN  = 32,
  parameter int unsigned STEP_DIV = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [7:0]  wr_char,
  input  logic        len_we,
  input  logic [5:0]  len_in,
  input  logic        start,
  input  logic        stop,
  output logic [63:0] o_text,
  output logic        o_cs,
  output logic        busy,
  output logic        wrap
);

  localparam int unsigned CntW    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STEP_DIV - 1);
  localparam logic [5:0]      MaxLen = 6'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StStatic, StScroll} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      offset_q, offset_d;
  logic [5:0]      len_q;
  logic [7:0]      char_buf_q [MAX_LEN];
  logic [63:0]     text_q, text_d, text_r;
  logic            cs_q, cs_d;
  logic            wrap_q, wrap_d;
  logic            busy_q;
  logic            tc;
  logic [5:0]      idx;

  assign tc = (cnt_q == CntMax);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    cs_d     = 1'b0;
    wrap_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // stop has priority over a coincident start
        if (start && !stop) begin
          state_d  = (len_q > 6'd8) ? StScroll : StStatic;
          cnt_d    = '0;
          offset_d = '0;
          cs_d     = 1'b1;
        end
      end
      StStatic, StScroll: begin
        if (stop) begin
          state_d  = StIdle;
          cnt_d    = '0;
          offset_d = '0;
        end else if (tc) begin
          cnt_d = '0;
          cs_d  = 1'b1;
          if (state_q == StScroll) begin
            if ({1'b0, offset_q} == len_q - 6'd1) begin
              offset_d = '0;
              wrap_d   = 1'b1;
            end else begin
              offset_d = offset_q + 5'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Window is rendered from the offset that will be current after this edge, so the
  // strobe lands exactly STEP_DIV cycles apart.
  always_comb begin
    text_r = '0;
    idx    = '0;
    for (int i = 0; i < 8; i++) begin
      idx = {1'b0, offset_d} + 6'(i);
      if (state_d == StScroll) begin
        if (idx >= len_q) idx = idx - len_q;
        text_r[(7-i)*8 +: 8] = char_buf_q[idx[4:0]];
      end else begin
        text_r[(7-i)*8 +: 8] = (idx < len_q) ? char_buf_q[idx[4:0]] : 8'h20;
      end
    end
  end

  assign text_d = cs_d ? text_r : text_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      offset_q <= '0;
      len_q    <= '0;
      text_q   <= {8{8'h20}};
      cs_q     <= 1'b0;
      wrap_q   <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) char_buf_q[i] <= 8'h20;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      text_q   <= text_d;
      cs_q     <= cs_d;
      wrap_q   <= wrap_d;
      busy_q   <= (state_d != StIdle);
      if (wr_en) char_buf_q[wr_addr] <= wr_char;
      if (len_we && state_q == StIdle) len_q <= (len_in > MaxLen) ? MaxLen : len_in;
    end
  end

  assign o_text = text_q;
  assign o_cs   = cs_q;
  assign busy   = busy_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_seg_text_scroller.sv
// Directed self-checking bench for seg_text_scroller with a 4-cycle scroll step.
module tb_seg_text_scroller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [7:0]  wr_char = '0;
  logic        len_we = 1'b0;
  logic [5:0]  len_in = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [63:0] o_text;
  logic        o_cs;
  logic        busy;
  logic        wrap;

  int n_checks = 0;
  int n_errors = 0;
  int glitches = 0;

  localparam logic [63:0] Spaces = 64'h2020202020202020;

  seg_text_scroller #(.MAX_LEN(32), .STEP_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_char (wr_char),
    .len_we  (len_we),
    .len_in  (len_in),
    .start   (start),
    .stop    (stop),
    .o_text  (o_text),
    .o_cs    (o_cs),
    .busy    (busy),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_char(input logic [4:0] a, input logic [7:0] c);
    wr_en = 1'b1; wr_addr = a; wr_char = c;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic set_len(input logic [5:0] l);
    len_we = 1'b1; len_in = l;
    tick();
    len_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // Cycles until the next o_cs; also tallies any text change without a strobe.
  task automatic wait_cs(output int n);
    logic [63:0] prev;
    prev = o_text;
    n = 0;
    do begin
      tick();
      n++;
      if (!o_cs && o_text !== prev) glitches++;
    end while (!o_cs && n < 40);
  endtask

  task automatic wait_wrap(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!wrap && n < 400);
  endtask

  initial begin
    int n;
    int cs_seen;
    logic [63:0] exp;
    logic [63:0] frozen;
    logic [7:0] hello [5];
    hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

    #12;
    check_eq("reset_text", o_text, Spaces);
    check_eq("reset_cs", 64'(o_cs), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_wrap", 64'(wrap), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Static message
    for (int i = 0; i < 5; i++) write_char(5'(i), hello[i]);
    set_len(6'd5);
    pulse_start();
    check_eq("hello_text", o_text, 64'h48454C4C4F202020);
    check_eq("hello_cs", 64'(o_cs), 64'd1);
    check_eq("hello_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 2; k++) begin
      wait_cs(n);
      check_eq("hello_period", 64'(n), 64'd4);
      check_eq("hello_hold", o_text, 64'h48454C4C4F202020);
    end
    pulse_stop();

    // Scrolling digits with wrap
    for (int i = 0; i < 10; i++) write_char(5'(i), 8'h30 + 8'(i));
    set_len(6'd10);
    pulse_start();
    check_eq("digits_first", o_text, "01234567");
    check_eq("digits_first_wrap", 64'(wrap), 64'd0);
    for (int k = 1; k <= 10; k++) begin
      wait_cs(n);
      check_eq("digits_period", 64'(n), 64'd4);
      for (int i = 0; i < 8; i++) exp[(7-i)*8 +: 8] = 8'h30 + 8'((k + i) % 10);
      check_eq("digits_text", o_text, exp);
      check_eq("digits_wrap", 64'(wrap), (k == 10) ? 64'd1 : 64'd0);
    end
    tick();
    check_eq("wrap_one_cycle", 64'(wrap), 64'd0);

    // Buffer write mid-scroll appears only at the next strobe
    write_char(5'd2, 8'h5A);
    check_eq("z_not_yet", o_text, "01234567");
    wait_cs(n);
    check_eq("z_visible", o_text, "1Z345678");
    check_eq("no_glitch", 64'(glitches), 64'd0);

    // Stop mid-scroll freezes the window
    frozen = o_text;
    tick();
    pulse_stop();
    check_eq("stop_busy", 64'(busy), 64'd0);
    cs_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (o_cs) cs_seen++;
      tick();
    end
    check_eq("stop_no_cs", 64'(cs_seen), 64'd0);
    check_eq("stop_frozen", o_text, frozen);

    // Coincident start/stop from idle: stop wins
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    cs_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_cs || busy) cs_seen++;
      tick();
    end
    check_eq("start_stop_idle", 64'(cs_seen), 64'd0);

    // Length clamp to 32 and length write ignored while scrolling
    set_len(6'd40);
    pulse_start();
    wait_wrap(n);
    check_eq("clamp_wrap_period", 64'(n), 64'd128);
    check_eq("clamp_wrap_cs", 64'(o_cs), 64'd1);
    check_eq("clamp_wrap_text", o_text, "01Z34567");
    len_we = 1'b1; len_in = 6'd9;
    tick();
    len_we = 1'b0;
    wait_wrap(n);
    check_eq("len_we_ignored", 64'(n + 1), 64'd128);

    // Asynchronous reset mid-scroll
    tick(); tick();
    rst = 1'b1;
    #2;
    check_eq("rst_text", o_text, Spaces);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_cs", 64'(o_cs), 64'd0);
    tick();
    rst = 1'b0;
    cs_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_cs || busy) cs_seen++;
    end
    check_eq("rst_quiet", 64'(cs_seen), 64'd0);

    // len=0 start renders blanks; reset blanked the buffer
    pulse_start();
    check_eq("len0_cs", 64'(o_cs), 64'd1);
    check_eq("len0_text", o_text, Spaces);
    pulse_stop();
    set_len(6'd8);
    pulse_start();
    check_eq("buf_reset_text", o_text, Spaces);
    check_eq("buf_reset_busy", 64'(busy), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_text_scroller.md
SEG_TEXT_SCROLLER -- requirements
Module: seg_text_scroller

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 32, meaning message buffer depth in characters, fixed at 32 for this revision.
REQ-002 The block SHALL have parameter STEP_DIV, default 50000000, meaning clk cycles per scroll step; legal range is 2 or more.
REQ-003 The block SHALL have port clk, input, width 1, system clock.
REQ-004 The block SHALL have port rst, input, width 1, reset, asynchronous, active-high.
REQ-005 The block SHALL have port wr_en, input, width 1, character write strobe.
REQ-006 The block SHALL have port wr_addr, input, width 5, character buffer index.
REQ-007 The block SHALL have port wr_char, input, width 8, ASCII character to write.
REQ-008 The block SHALL have port len_we, input, width 1, message length write strobe.
REQ-009 The block SHALL have port len_in, input, width 6, message length in characters.
REQ-010 The block SHALL have port start, input, width 1, single-cycle start pulse.
REQ-011 The block SHALL have port stop, input, width 1, single-cycle stop pulse.
REQ-012 The block SHALL have port o_text, output, width 64, 8-character window for the display ASCII data input; [63:56] is the leftmost digit.
REQ-013 The block SHALL have port o_cs, output, width 1, one-cycle latch strobe for the display chip select.
REQ-014 The block SHALL have port busy, output, width 1, high in the STATIC and SCROLL states.
REQ-015 The block SHALL have port wrap, output, width 1, one-cycle pulse on offset wrap.

Function
REQ-016 The block SHALL have exactly three states: IDLE, STATIC and SCROLL.
REQ-017 When wr_en=1, buf[wr_addr] SHALL be written with wr_char at the clock edge, in any state.
REQ-018 When len_we=1 in IDLE, len SHALL be loaded from len_in, with values above 32 clamped to 32.
REQ-019 When len_we=1 while busy=1, the length write SHALL be ignored.
REQ-020 In IDLE, a start pulse SHALL move the block to STATIC when len<=8 and to SCROLL when len>8; offset and step counter SHALL clear to 0.
REQ-021 In STATIC, o_text character i (i=0..7, leftmost first) SHALL be buf[i] when i<len, else 0x20.
REQ-022 In SCROLL, o_text character i SHALL be buf[(offset+i) mod len].
REQ-023 The block SHALL render o_text and pulse o_cs=1 in the cycle after start is accepted.
REQ-024 In STATIC and SCROLL, the step counter SHALL count 0..STEP_DIV-1 and then wrap to 0.
REQ-025 At step-counter terminal count in SCROLL, offset SHALL advance: offset<=offset+1, or 0 when offset=len-1.
REQ-026 At step-counter terminal count in STATIC, offset SHALL remain 0.
REQ-027 One cycle after each terminal count, o_text SHALL be re-rendered from the current offset and current buf contents, and o_cs SHALL pulse for one cycle.
REQ-028 Steady-state o_cs spacing SHALL be exactly STEP_DIV cycles.
REQ-029 Buffer writes SHALL become visible at the next render, with no glitch between renders.
REQ-030 wrap SHALL pulse for one cycle, coincident with the o_cs of the render that follows an offset change from len-1 to 0.
REQ-031 A stop pulse SHALL move the block to IDLE from any state; o_text SHALL hold its last value, o_cs SHALL remain 0, and the counter SHALL clear.
REQ-032 When start and stop are asserted in the same cycle, stop SHALL win.
REQ-033 A start pulse while busy=1 SHALL be ignored.
REQ-034 A start pulse with len=0 SHALL enter STATIC and render 8 spaces (0x2020202020202020).
REQ-035 o_text SHALL only change in cycles where o_cs=1.
REQ-036 busy SHALL be registered and SHALL be high one cycle after start is accepted.

Reset
REQ-037 On rst=1, all buf entries SHALL be set to 0x20, len to 0, offset to 0, the counter to 0 and the state to IDLE.
REQ-038 On rst=1, o_text SHALL be 0x2020202020202020 and o_cs, busy and wrap SHALL be 0.
REQ-039 Asserting rst mid-scroll SHALL abort immediately and produce no o_cs pulse on release.

Verification (STEP_DIV=4)
REQ-040 Bench SHALL check: write "HELLO" at addr 0..4, len=5, start -> next cycle o_text=0x48454C4C4F202020, o_cs=1, busy=1, then o_cs repeats every 4 cycles with unchanged text.
REQ-041 Bench SHALL check: write "0123456789", len=10, start -> successive renders "01234567", "12345678", ..., "90123456", then "01234567" with wrap=1.
REQ-042 Bench SHALL check: mid-SCROLL, write buf[2]='Z' -> it appears only at the next o_cs, at the window position matching its index.
REQ-043 Bench SHALL check: start and stop in the same cycle from IDLE -> block stays IDLE, no o_cs; stop mid-SCROLL -> o_text frozen, busy=0 next cycle.
REQ-044 Bench SHALL check: len_in=40 -> len=32; len_we during SCROLL -> ignored and wrap period unchanged.
REQ-045 Bench SHALL check: rst asserted mid-SCROLL -> o_text=0x2020202020202020, busy=0, and no o_cs until the next start.
